// File: rtl/aes_256_pkg.sv
// Shared AES-256 inverse-cipher definitions: sizes, Rcon, FSM encoding and GF(2^8) byte helpers.
package aes_256_pkg;
  localparam int NR    = 14;
  localparam int NK    = 8;
  localparam int KEY_W = 32 * NK;

  // Rcon[0] is unused; key-expansion step i uses Rcon[i/2]
  localparam logic [7:0][7:0] RCON = {8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

  typedef enum logic [2:0] {S_IDLE, S_EXPAND, S_ADDKEY, S_ROUND, S_DONE} state_e;
  typedef logic [NR:0][127:0] rk_file_t;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse; maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_fwd(w[31:24]), sbox_fwd(w[23:16]), sbox_fwd(w[15:8]), sbox_fwd(w[7:0])};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction
endpackage

// File: rtl/aes_256_dec_if.sv
// Request/result bundle between a host and the AES-256 decryptor.
interface aes_256_dec_if;
  import aes_256_pkg::*;
  logic             en;
  logic [KEY_W-1:0] cipher_key;
  logic [127:0]     data_in;
  logic [127:0]     data_out;
  logic             done;

  modport master (output en, cipher_key, data_in, input data_out, done);
  modport slave  (input en, cipher_key, data_in, output data_out, done);
endinterface

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box: inverse affine transform followed by GF(2^8) inversion.
module aes_inv_sbox
  import aes_256_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);
  assign dout = gf_inv(rotl8(din, 1) ^ rotl8(din, 3) ^ rotl8(din, 6) ^ 8'h05);
endmodule

// File: rtl/aes_256_dec.sv
// Iterative AES-256 InvCipher, one round per clock; AES_256_DEC_KEYCACHE_EN skips re-expansion of a repeated key.
// states: IDLE wait for en | EXPAND build rk2..rk14 | ADDKEY data^rk14 | ROUND inverse rounds 13..0 | DONE result valid
module aes_256_dec
  import aes_256_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  aes_256_dec_if.slave bus
);
  state_e       state, state_nxt;
  logic [3:0]   cnt, widx;
  logic [127:0] data_r, prev1, prev2, sr, sb, ark, rnd_out;
  logic [31:0]  t_word, w0, w1, w2, w3;
  rk_file_t     rk_file;
  logic         hit;

`ifdef AES_256_DEC_KEYCACHE_EN
  logic key_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                key_valid <= 1'b0;
    else if (state == S_EXPAND && cnt == 4'd0) key_valid <= 1'b1;
  // rk0/rk1 are the raw key halves, so they double as the stored key
  assign hit = key_valid && (bus.cipher_key == {rk_file[0], rk_file[1]});
`else
  assign hit = 1'b0;
`endif

  assign widx = 4'(NR) - cnt;

  always_comb begin
    prev2 = rk_file[widx - 4'd2];
    prev1 = rk_file[widx - 4'd1];
    if (widx[0]) t_word = sub_word(prev1[31:0]);
    else         t_word = sub_word({prev1[23:0], prev1[31:24]}) ^ {RCON[widx[3:1]], 24'h0};
    w0 = prev2[127:96] ^ t_word;
    w1 = prev2[95:64]  ^ w0;
    w2 = prev2[63:32]  ^ w1;
    w3 = prev2[31:0]   ^ w2;
  end

  assign sr = inv_shift_rows(data_r);
  for (genvar b = 0; b < 16; b++) begin : g_isb
    aes_inv_sbox u_isb (.din(sr[127-8*b -: 8]), .dout(sb[127-8*b -: 8]));
  end
  assign ark     = sb ^ rk_file[cnt];
  assign rnd_out = (cnt == 4'd0) ? ark : inv_mix_columns(ark);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.en) state_nxt = hit ? S_ADDKEY : S_EXPAND;
      S_EXPAND: if (cnt == 4'd0) state_nxt = S_ADDKEY;
      S_ADDKEY: state_nxt = S_ROUND;
      S_ROUND:  if (cnt == 4'd0) state_nxt = S_DONE;
      S_DONE:   if (bus.done && !bus.en) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt          <= 4'd0;
      data_r       <= '0;
      rk_file      <= '0;
      bus.data_out <= '0;
      bus.done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.en) begin
          data_r     <= bus.data_in;
          rk_file[0] <= bus.cipher_key[255:128];
          rk_file[1] <= bus.cipher_key[127:0];
          cnt        <= 4'(NR - 2);
        end
        S_EXPAND: begin
          rk_file[widx] <= {w0, w1, w2, w3};
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        S_ADDKEY: begin
          data_r <= data_r ^ rk_file[NR];
          cnt    <= 4'(NR - 1);
        end
        S_ROUND: begin
          data_r <= rnd_out;
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        S_DONE: begin
          // first DONE cycle publishes the result; afterwards wait for en to drop
          if (!bus.done) begin
            bus.done     <= 1'b1;
            bus.data_out <= data_r;
          end else if (!bus.en) begin
            bus.done <= 1'b0;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_aes_256_dec.sv
// Self-checking bench for aes_256_dec against a forward AES-256 reference built from first principles.
module tb_aes_256_dec;
  logic clk, rst_n;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] sbox_tab [256];

`ifdef AES_256_DEC_KEYCACHE_EN
  localparam int LAT_HIT = 16;
`else
  localparam int LAT_HIT = 29;
`endif
  localparam int LAT_MISS = 29;

  aes_256_dec_if bus_i ();
  aes_256_dec dut (.clk(clk), .rst_n(rst_n), .bus(bus_i));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rl(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b};
    return d[15-k -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [255:0] key, input logic [127:0] pt);
    logic [31:0] w [60];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8];
    for (int rnd = 0; rnd <= 14; rnd++) begin
      if (rnd > 0) begin
        for (int b = 0; b < 16; b++) s[b] = sbox_tab[s[b]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
        s = t;
        if (rnd < 14)
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
          end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
    end
    o = '0;
    for (int b = 0; b < 16; b++) o[127-8*b -: 8] = s[b];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // hold == 0: en drops right after the sample edge; hold > 0: en stays high for hold cycles of DONE
  task automatic run_op(input string tag, input logic [255:0] key, input logic [127:0] ct,
                        input logic [127:0] pt, input int exp_lat, input int hold);
    int   n;
    logic stable;
    @(negedge clk);
    bus_i.cipher_key = key;
    bus_i.data_in    = ct;
    bus_i.en         = 1'b1;
    @(posedge clk); #1;
    bus_i.cipher_key = rnd256();
    bus_i.data_in    = rnd128();
    if (hold == 0) bus_i.en = 1'b0;
    n = 0;
    while (bus_i.done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 128'(n), 128'(exp_lat));
    check({tag, " plaintext"}, bus_i.data_out, pt);
    if (hold == 0) begin
      @(posedge clk); #1;
      check({tag, " done pulse"}, 128'(bus_i.done), 128'(0));
    end else begin
      stable = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (bus_i.done !== 1'b1 || bus_i.data_out !== pt) stable = 1'b0;
      end
      check({tag, " hold stable"}, 128'(stable), 128'(1));
      bus_i.en = 1'b0;
      @(posedge clk); #1;
      check({tag, " done drop"}, 128'(bus_i.done), 128'(0));
      check({tag, " data kept"}, bus_i.data_out, pt);
      repeat (3) @(posedge clk);
      #1;
      check({tag, " no restart"}, 128'(bus_i.done), 128'(0));
    end
  endtask

  initial begin
    logic [7:0]   p, q, x;
    logic [255:0] key, fips_key, rt_key;
    logic [127:0] pt, ct, rt_pt;

    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sbox_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tab[0] = 8'h63;

    rst_n = 1'b0;
    bus_i.en = 1'b0;
    bus_i.cipher_key = '0;
    bus_i.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset done", 128'(bus_i.done), 128'(0));
    check("reset data_out", bus_i.data_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    fips_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    run_op("fips", fips_key, 128'h8ea2b7ca516745bfeafc49904b496089,
           128'h00112233445566778899aabbccddeeff, LAT_MISS, 10);
    run_op("fips rerun", fips_key, 128'h8ea2b7ca516745bfeafc49904b496089,
           128'h00112233445566778899aabbccddeeff, LAT_HIT, 0);

    rt_key = 256'hf4df1409a310982dd708613b072c351f81777d85f0ae732bbe71ca1510eb3d60;
    rt_pt  = 128'h2a179373117e3de9969f402ee2bec16b;
    run_op("round trip", rt_key, ref_encrypt(rt_key, rt_pt), rt_pt, LAT_MISS, 0);

    key = '0;
    for (int i = 0; i < 4; i++) begin
      key = rnd256();
      pt  = rnd128();
      run_op($sformatf("random %0d", i), key, ref_encrypt(key, pt), pt, LAT_MISS, (i == 1) ? 3 : 0);
    end
    pt = rnd128();
    run_op("same key", key, ref_encrypt(key, pt), pt, LAT_HIT, 0);
    key = rnd256();
    pt  = rnd128();
    run_op("new key", key, ref_encrypt(key, pt), pt, LAT_MISS, 0);

    key = rnd256();
    pt  = rnd128();
    ct  = ref_encrypt(key, pt);
    @(negedge clk);
    bus_i.cipher_key = key;
    bus_i.data_in    = ct;
    bus_i.en         = 1'b1;
    @(posedge clk); #1;
    bus_i.en = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort done", 128'(bus_i.done), 128'(0));
    check("abort data_out", bus_i.data_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after reset", key, ct, pt, LAT_MISS, 0);
    run_op("after reset rerun", key, ct, pt, LAT_HIT, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
